// File: rtl/synchronous_fifo.sv
// -----------------------------------------------------------------------------
// synchronous_fifo
//
// Purpose
//   Single-clock first-in/first-out buffer between a producer and a consumer
//   that share one clock domain. Holds up to DEPTH words, reports full/empty
//   for flow control, and presents read data from a register one cycle after
//   the read is accepted.
//
// Parameters
//   DATA_WIDTH  width of each stored word (data_in / data_out)
//   DEPTH       number of storage entries; power of 2, >= 2
//
// Ports
//   clk       in   1           rising-edge clock; all state changes on posedge
//   reset_n   in   1           synchronous reset, ACTIVE-HIGH (1 = reset)
//                              despite the _n suffix
//   wr_en     in   1           write request; data_in captured when accepted
//   r_en      in   1           read request
//   data_in   in   DATA_WIDTH  write data
//   data_out  out  DATA_WIDTH  registered read data
//   full      out  1           1 when DEPTH entries are held
//   empty     out  1           1 when no entries are held
// -----------------------------------------------------------------------------
module synchronous_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic                  r_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    // Address bits; each pointer carries one extra MSB used as a wrap flag so
    // that "all slots used" and "no slots used" can be told apart.
    localparam int unsigned PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    // -------------------------------------------------------------------------
    // Flags, derived straight from the pointer registers with no extra latency
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0] wr_addr;
    logic [PTR_W-1:0] rd_addr;

    assign wr_addr = wr_ptr_q[PTR_W-1:0];
    assign rd_addr = rd_ptr_q[PTR_W-1:0];

    assign empty = (wr_ptr_q == rd_ptr_q);
    // Same slot but the writer has lapped the reader once: every entry is used.
    assign full  = (wr_addr == rd_addr) && (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);

    // A request is honoured only when the matching flag allows it; a write
    // while full or a read while empty simply has no effect.
    logic wr_accept;
    logic rd_accept;
    logic mem_we;

    assign wr_accept = wr_en && !full;
    assign rd_accept = r_en && !empty;
    // Reset takes priority, so an accepted-looking write during reset must not
    // touch storage either (keeps the array free of stray updates).
    assign mem_we    = wr_accept && !reset_n;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;

        if (reset_n) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            data_out_d = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            // data_out only changes on an accepted read, so it holds its last
            // value across idle cycles and ignored reads.
            if (rd_accept) begin
                data_out_d = mem_q[rd_addr];
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        data_out_q <= data_out_d;
    end

    // NOTE: the storage array is deliberately not reset; the pointers reset to
    // "empty", so stale contents are unreachable and the array can map onto
    // plain register/RAM cells without a reset network.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_synchronous_fifo.sv
// -----------------------------------------------------------------------------
// tb_synchronous_fifo
//
// Self-checking bench for synchronous_fifo. A queue-based reference model
// tracks the held words, the registered output and the flags; directed
// sequences cover reset, fill/drain, wrap-around, simultaneous access and
// mid-operation reset, followed by a long randomized run.
// -----------------------------------------------------------------------------
module tb_synchronous_fifo;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned DEPTH      = 8;

    logic                  clk;
    logic                  reset_n;
    logic                  wr_en;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;

    synchronous_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .r_en     (r_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Reference model: words held, in order, plus the last word read out.
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] model_q[$];
    logic [DATA_WIDTH-1:0] model_dout;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     tag, actual, expected, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the FIFO rules, then
    // compare all outputs shortly after the edge.
    task automatic cycle(input logic rst, input logic wr, input logic rd,
                         input logic [DATA_WIDTH-1:0] din);
        bit can_wr;
        bit can_rd;
        reset_n = rst;
        wr_en   = wr;
        r_en    = rd;
        data_in = din;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            model_dout = '0;
        end else begin
            can_wr = wr && (model_q.size() < DEPTH);
            can_rd = rd && (model_q.size() > 0);
            if (can_rd) model_dout = model_q.pop_front();
            if (can_wr) model_q.push_back(din);
        end
        #1;
        check("data_out", 32'(data_out), 32'(model_dout));
        check("full",     32'(full),     32'(model_q.size() == DEPTH));
        check("empty",    32'(empty),    32'(model_q.size() == 0));
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic do_write(input logic [DATA_WIDTH-1:0] din);
        cycle(1'b0, 1'b1, 1'b0, din);
    endtask

    task automatic do_read();
        cycle(1'b0, 1'b0, 1'b1, '0);
    endtask

    task automatic do_idle();
        cycle(1'b0, 1'b0, 1'b0, '0);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        logic [DATA_WIDTH-1:0] w;
        int unsigned           wr_pct;
        int unsigned           rd_pct;

        n_checks   = 0;
        n_fail     = 0;
        model_dout = '0;
        reset_n    = 1'b1;
        wr_en      = 1'b0;
        r_en       = 1'b0;
        data_in    = '0;

        // 1. Reset, then idle with reset released.
        do_reset();
        check("reset_empty", 32'(empty),    32'd1);
        check("reset_full",  32'(full),     32'd0);
        check("reset_dout",  32'(data_out), 32'h0);
        repeat (3) do_idle();

        // 2. Fill with 0x11..0x88, then a dropped write while full.
        for (int i = 1; i <= 8; i++) begin
            w = DATA_WIDTH'(8'h11 * i);
            do_write(w);
            if (i == 1) check("first_write_empty", 32'(empty), 32'd0);
        end
        check("fill_full", 32'(full), 32'd1);
        do_write(8'hFF);
        check("overflow_full", 32'(full), 32'd1);

        // 3. Drain, then a read while empty keeps the last word.
        for (int i = 1; i <= 8; i++) begin
            do_read();
            check("drain_seq", 32'(data_out), 32'(8'h11 * i));
        end
        check("drain_empty", 32'(empty), 32'd1);
        do_read();
        check("underflow_dout", 32'(data_out), 32'h88);

        // 4. Wrap: 5 in/out, then a full 8 in/out crossing the pointer wrap.
        for (int i = 0; i < 5; i++) do_write(DATA_WIDTH'(8'hA0 + i));
        for (int i = 0; i < 5; i++) do_read();
        for (int i = 0; i < 8; i++) do_write(DATA_WIDTH'(8'hC0 + i));
        check("wrap_full", 32'(full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            do_read();
            check("wrap_seq", 32'(data_out), 32'(8'hC0 + i));
        end
        check("wrap_empty", 32'(empty), 32'd1);

        // 5a. Simultaneous read/write with 4 entries held.
        for (int i = 0; i < 4; i++) do_write(DATA_WIDTH'(8'h30 + i));
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 1'b1, DATA_WIDTH'(8'h50 + i));
            check("sim_occupancy", 32'(model_q.size()), 32'd4);
        end
        for (int i = 0; i < 4; i++) do_read();
        check("sim_last", 32'(data_out), 32'h59);

        // 5b. Simultaneous while full: only the read happens.
        for (int i = 0; i < 8; i++) do_write(DATA_WIDTH'(8'h60 + i));
        cycle(1'b0, 1'b1, 1'b1, 8'hEE);
        check("full_rw_dout", 32'(data_out), 32'h60);
        check("full_rw_full", 32'(full),     32'd0);
        for (int i = 0; i < 7; i++) do_read();
        check("full_rw_tail", 32'(data_out), 32'h67);

        // 5c. Simultaneous while empty: only the write happens.
        cycle(1'b0, 1'b1, 1'b1, 8'h77);
        check("empty_rw_empty", 32'(empty),    32'd0);
        check("empty_rw_dout",  32'(data_out), 32'h67);
        do_read();
        check("empty_rw_word",  32'(data_out), 32'h77);

        // 6. Mid-operation reset discards queued words.
        for (int i = 0; i < 3; i++) do_write(DATA_WIDTH'(8'h90 + i));
        do_reset();
        check("midrst_empty", 32'(empty),    32'd1);
        check("midrst_dout",  32'(data_out), 32'h0);
        do_read();
        check("midrst_noread", 32'(data_out), 32'h0);

        // Randomized run: the write/read bias shifts every 64 cycles so the
        // FIFO repeatedly sweeps between empty and full; rare resets included.
        wr_pct = 50;
        rd_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                wr_pct = $urandom_range(10, 90);
                rd_pct = $urandom_range(10, 90);
            end
            cycle(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 99) < wr_pct),
                  ($urandom_range(0, 99) < rd_pct),
                  DATA_WIDTH'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
